priority_arbiter: RTL and testbench
===================================

# priority_arbiter

Registered, parametrised successor to the combinational priority encoder. It arbitrates among 2**output_lines level-sensitive requesters using either fixed lowest-index-first or round-robin priority. The chosen index is held in an output register behind a valid/ready handshake. Intended for interrupt-source selection and shared-port arbitration in the MIPS core.

## Interface
- output_lines, default 2: index width; input_lines = 2**output_lines (derived localparam, not overridable).
- round_robin, default 0: 0 = fixed priority (index 0 highest); 1 = rotating priority.

- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock, asynchronous assert, active-high.
- req  input  input_lines  request vector, level-sensitive, bit i = requester i.
- mask  input  input_lines  bit i = 1 blocks requester i.
- out_ready  input  1  consumer accepts the current grant.
- out_valid  output  1  grant register holds a live grant.
- out_index  output  output_lines  binary index of the granted requester.
- out_onehot  output  input_lines  one-hot form of out_index; all zero when out_valid = 0.
- none  output  1  combinational: no unmasked request, i.e. ~|(req & ~mask).

## Operation
- Eligible vector: elig = req & ~mask & ~excl.
  - excl = out_onehot when (out_valid & out_ready); otherwise 0.
  - The accepted requester cannot be re-granted on its own acceptance edge.
- Pointer ptr (output_lines bits): the search starts at ptr and moves upward with wrap-around (ptr, ptr+1, …, input_lines-1, 0, …).
  - Fixed mode: ptr is constantly 0, so this is a pure lowest-index-first encoder.
- Load condition: load = ~out_valid | out_ready.
  - On a clock edge with load = 1 and elig ≠ 0: out_valid ← 1, out_index ← winner, out_onehot ← 1 << winner.
  - On a load edge with elig = 0: out_valid ← 0, out_onehot ← 0, out_index holds its value.
  - With load = 0 (stalled): all grant registers hold, whatever req or mask do.
- Accept = out_valid & out_ready on a rising edge.
  - In round-robin mode, ptr ← (out_index + 1) mod input_lines, wrapping from input_lines-1 to 0.
  - The ptr update and the new-grant load happen on the same edge. The new winner is computed with the old ptr plus excl.
- Requester protocol: drop req on the cycle after its acceptance. A held req is re-arbitrated normally.
- Fixed mode with all requesters held: the grant alternates between the two lowest indices (a fairness limit of fixed mode; by design).
- States:
  - IDLE (out_valid = 0): IDLE → GRANT when elig ≠ 0.
  - GRANT (out_valid = 1):
    - Stays in GRANT while stalled.
    - On accept, GRANT → GRANT when elig ≠ 0 (back-to-back).
    - On accept, GRANT → IDLE when elig = 0.

## Timing
- Reset values, applied immediately on rst assertion regardless of clk: out_valid = 0, out_index = 0, out_onehot = 0, ptr = 0.
- none is combinational and follows req and mask with no reset dependence.
- Reset mid-grant: the pending grant is discarded, no accept is reported, and the ptr history is lost.
- The first edge after rst deasserts performs a normal load.
- Latency: req rising before edge N gives out_valid = 1 after edge N (1 cycle).
- Throughput: one grant per cycle when out_ready is held high.
- Stability: out_index and out_onehot are constant throughout any cycle where out_valid = 1 and out_ready = 0.
- out_ready while out_valid = 0: acts as load only; no accept and no ptr change.
- mask changes take effect at the next load edge only; a stalled grant is never revoked by mask.

## Test plan
- Async reset: with out_valid = 1, out_index = 2, assert rst between edges → out_valid = 0, out_index = 0, out_onehot = 0000 without waiting for a clock; none still tracks req.
- Fixed mode, 4 inputs: req = 1010, out_ready = 1.
  - Grant index 1, onehot 0010, one edge after req.
  - Requester 1 drops req → next grant is index 3.
  - req = 0 afterwards → out_valid = 0 and none = 1.
- Round-robin, req = 1111 held, out_ready = 1 → out_index sequence 0, 1, 2, 3, 0, one per cycle, out_valid continuously 1.
- Round-robin wrap: after index 2 is accepted (ptr = 3), req = 0101 → grant index 0 (search order 3, 0, 1, 2), not index 2.
- Backpressure: grant index 2 valid, out_ready = 0 for 5 cycles while req changes to 0001 → out_index stays 2 and out_valid stays 1. On out_ready = 1, the next edge loads index 0.
- Mask: mask = 0001, req = 0011 → grant index 1 and none = 0. Then req = 0001 → none = 1, and after accept out_valid = 0.

Source files
------------

// File: rtl/priority_arbiter_if.sv
// rtl/priority_arbiter_if.sv - request/grant bundle between requesters, consumer and arbiter
interface priority_arbiter_if #(
    parameter int output_lines = 2
);
    localparam int input_lines = 2 ** output_lines;

    logic [input_lines-1:0]  req;
    logic [input_lines-1:0]  mask;
    logic                    out_ready;
    logic                    out_valid;
    logic [output_lines-1:0] out_index;
    logic [input_lines-1:0]  out_onehot;
    logic                    none;

    modport master (
        output req,
        output mask,
        output out_ready,
        input  out_valid,
        input  out_index,
        input  out_onehot,
        input  none
    );

    modport slave (
        input  req,
        input  mask,
        input  out_ready,
        output out_valid,
        output out_index,
        output out_onehot,
        output none
    );
endinterface

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - registered fixed/round-robin priority arbiter with valid/ready grant
module priority_arbiter #(
    parameter int output_lines = 2,
    parameter bit round_robin  = 1'b0
) (
    input logic                clk,
    input logic                rst,
    priority_arbiter_if.slave  bus
);
    localparam int input_lines = 2 ** output_lines;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state, state_next;
    logic [output_lines-1:0] index_q, index_next;
    logic [input_lines-1:0]  onehot_q, onehot_next;
    logic [output_lines-1:0] ptr_q, ptr_next;

    logic [input_lines-1:0]  excl;
    logic [input_lines-1:0]  elig;
    logic                    found;
    logic [output_lines-1:0] winner;
    logic [output_lines-1:0] idx;
    logic [input_lines-1:0]  win_onehot;
    logic                    valid;

    assign valid          = (state == GRANT);
    assign bus.out_valid  = valid;
    assign bus.out_index  = index_q;
    assign bus.out_onehot = onehot_q;
    assign bus.none       = ~|(bus.req & ~bus.mask);

    // The requester being accepted this edge is excluded so it cannot win twice in a row.
    always_comb begin
        excl       = (valid && bus.out_ready) ? onehot_q : '0;
        elig       = bus.req & ~bus.mask & ~excl;
        found      = 1'b0;
        winner     = '0;
        idx        = '0;
        for (int k = 0; k < input_lines; k++) begin
            idx = ptr_q + output_lines'(k);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        win_onehot         = '0;
        win_onehot[winner] = 1'b1;
    end

    always_comb begin
        state_next  = state;
        index_next  = index_q;
        onehot_next = onehot_q;
        ptr_next    = ptr_q;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next  = GRANT;
                    index_next  = winner;
                    onehot_next = win_onehot;
                end
            end
            GRANT: begin
                if (bus.out_ready) begin
                    if (round_robin) ptr_next = index_q + 1'b1;
                    if (found) begin
                        index_next  = winner;
                        onehot_next = win_onehot;
                    end else begin
                        state_next  = IDLE;
                        onehot_next = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            index_q  <= '0;
            onehot_q <= '0;
            ptr_q    <= '0;
        end else begin
            state    <= state_next;
            index_q  <= index_next;
            onehot_q <= onehot_next;
            ptr_q    <= ptr_next;
        end
    end
endmodule

// File: tb/tb_priority_arbiter.sv
// tb/tb_priority_arbiter.sv - directed checks of fixed and round-robin arbiters
module tb_priority_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    priority_arbiter_if #(.output_lines(2)) if_fx ();
    priority_arbiter_if #(.output_lines(2)) if_rr ();

    priority_arbiter #(.output_lines(2), .round_robin(1'b0)) dut_fx (
        .clk (clk),
        .rst (rst),
        .bus (if_fx)
    );

    priority_arbiter #(.output_lines(2), .round_robin(1'b1)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (if_rr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_exp [5];
        rr_exp = '{0, 1, 2, 3, 0};

        if_fx.req = '0; if_fx.mask = '0; if_fx.out_ready = 1'b0;
        if_rr.req = '0; if_rr.mask = '0; if_rr.out_ready = 1'b0;

        #2;
        check("rst_valid",  if_fx.out_valid,  0);
        check("rst_index",  if_fx.out_index,  0);
        check("rst_onehot", if_fx.out_onehot, 0);
        check("rst_none",   if_fx.none,       1);
        tick();
        rst = 1'b0;

        // fixed priority: 1010 -> index 1, then 3, then idle
        if_fx.req = 4'b1010; if_fx.out_ready = 1'b1;
        #1 check("fx_none_busy", if_fx.none, 0);
        tick();
        check("fx_g1_valid",  if_fx.out_valid,  1);
        check("fx_g1_index",  if_fx.out_index,  1);
        check("fx_g1_onehot", if_fx.out_onehot, 4'b0010);
        if_fx.req = 4'b1000;
        tick();
        check("fx_g3_index",  if_fx.out_index,  3);
        check("fx_g3_onehot", if_fx.out_onehot, 4'b1000);
        if_fx.req = 4'b0000;
        tick();
        check("fx_idle_valid",  if_fx.out_valid,  0);
        check("fx_idle_onehot", if_fx.out_onehot, 0);
        check("fx_idle_index",  if_fx.out_index,  3);
        check("fx_idle_none",   if_fx.none,       1);

        // fixed priority with everyone held alternates between 0 and 1
        if_fx.req = 4'b1111;
        tick(); check("fx_alt0", if_fx.out_index, 0);
        tick(); check("fx_alt1", if_fx.out_index, 1);
        tick(); check("fx_alt2", if_fx.out_index, 0);
        if_fx.req = 4'b0000;
        tick(); check("fx_alt_idle", if_fx.out_valid, 0);

        // backpressure holds index 2 while req changes
        if_fx.req = 4'b0100; if_fx.out_ready = 1'b0;
        tick();
        check("bp_load_index", if_fx.out_index, 2);
        if_fx.req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid",  if_fx.out_valid,  1);
            check("bp_hold_index",  if_fx.out_index,  2);
            check("bp_hold_onehot", if_fx.out_onehot, 4'b0100);
        end
        if_fx.out_ready = 1'b1;
        tick();
        check("bp_release_valid", if_fx.out_valid, 1);
        check("bp_release_index", if_fx.out_index, 0);
        if_fx.req = 4'b0000;
        tick();

        // asynchronous reset in the middle of a stalled grant
        if_fx.req = 4'b0100; if_fx.out_ready = 1'b0;
        tick();
        check("ar_pre_index", if_fx.out_index, 2);
        #2 rst = 1'b1;
        #1;
        check("ar_valid",  if_fx.out_valid,  0);
        check("ar_index",  if_fx.out_index,  0);
        check("ar_onehot", if_fx.out_onehot, 0);
        check("ar_none_busy", if_fx.none, 0);
        if_fx.req = 4'b0000;
        #1 check("ar_none_idle", if_fx.none, 1);
        rst = 1'b0;
        if_fx.req = 4'b0010; if_fx.out_ready = 1'b1;
        tick();
        check("ar_first_load", if_fx.out_index, 1);
        check("ar_first_valid", if_fx.out_valid, 1);
        if_fx.req = 4'b0000;
        tick();

        // mask blocks requester 0
        if_fx.mask = 4'b0001; if_fx.req = 4'b0011;
        #1 check("mask_none_busy", if_fx.none, 0);
        tick();
        check("mask_index", if_fx.out_index, 1);
        if_fx.req = 4'b0001;
        #1 check("mask_none_masked", if_fx.none, 1);
        tick();
        check("mask_idle", if_fx.out_valid, 0);

        // round-robin rotation with everyone held
        if_rr.req = 4'b1111; if_rr.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_seq_valid", if_rr.out_valid, 1);
            check("rr_seq_index", if_rr.out_index, rr_exp[i]);
        end
        tick(); check("rr_seq_index5", if_rr.out_index, 1);
        tick(); check("rr_seq_index6", if_rr.out_index, 2);
        if_rr.req = 4'b0000;
        tick(); check("rr_drain", if_rr.out_valid, 0);

        // pointer sits at 3 after index 2 was accepted
        if_rr.req = 4'b0101;
        tick(); check("rr_wrap_index", if_rr.out_index, 0);
        tick(); check("rr_wrap_next",  if_rr.out_index, 2);
        if_rr.req = 4'b0000;
        tick(); check("rr_final_idle", if_rr.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
